// File: rtl/sap_isa_pkg.sv
// SAP-16 instruction set constants, T-state encodings and the control strobe bundle
// shared by the sequencer and its decoder.
package sap_isa_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_STA = 4'h4;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h5;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [STATE_W-1:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } tstate_e;

  // Field order matches the strobe port order on ctrl_seq.
  typedef struct packed {
    logic pc_oe;
    logic ram_oe;
    logic ir_oe;
    logic a_oe;
    logic alu_oe;
    logic pc_inc;
    logic pc_write;
    logic mar_load;
    logic ir_load;
    logic a_load;
    logic b_load;
    logic flags_load;
    logic out_load;
    logic ram_we;
    logic alu_sub;
  } strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational strobe decode: T-state, opcode and flags to the strobe bundle,
// plus end-of-instruction and halt indications for the sequencer.
module ctrl_decode
  import sap_isa_pkg::*;
(
  input  tstate_e          state_i,
  input  logic [OPC_W-1:0] opcode_i,
  input  logic             flag_c_i,
  input  logic             flag_z_i,
  output strobes_t         strobes_o,
  output logic             end_o,
  output logic             hlt_o
);

  always_comb begin
    strobes_o = '0;
    end_o     = 1'b0;
    hlt_o     = 1'b0;
    case (state_i)
      T0: begin
        strobes_o.pc_oe    = 1'b1;
        strobes_o.mar_load = 1'b1;
      end
      T1: begin
        strobes_o.ram_oe  = 1'b1;
        strobes_o.ir_load = 1'b1;
        strobes_o.pc_inc  = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_NOP: end_o = 1'b1;
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            strobes_o.ir_oe    = 1'b1;
            strobes_o.mar_load = 1'b1;
          end
          OP_LDI: begin
            strobes_o.ir_oe  = 1'b1;
            strobes_o.a_load = 1'b1;
            end_o            = 1'b1;
          end
          OP_JMP: begin
            strobes_o.ir_oe    = 1'b1;
            strobes_o.pc_write = 1'b1;
            end_o              = 1'b1;
          end
          OP_JC: begin
            strobes_o.ir_oe    = flag_c_i;
            strobes_o.pc_write = flag_c_i;
            end_o              = 1'b1;
          end
          OP_JZ: begin
            strobes_o.ir_oe    = flag_z_i;
            strobes_o.pc_write = flag_z_i;
            end_o              = 1'b1;
          end
          OP_OUT: begin
            strobes_o.a_oe     = 1'b1;
            strobes_o.out_load = 1'b1;
            end_o              = 1'b1;
          end
          OP_HLT: hlt_o = 1'b1;
          default: end_o = 1'b1;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            strobes_o.ram_oe = 1'b1;
            strobes_o.a_load = 1'b1;
            end_o            = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            strobes_o.ram_oe = 1'b1;
            strobes_o.b_load = 1'b1;
          end
          OP_STA: begin
            strobes_o.a_oe   = 1'b1;
            strobes_o.ram_we = 1'b1;
            end_o            = 1'b1;
          end
          default: end_o = 1'b1;
        endcase
      end
      T4: begin
        end_o = 1'b1;
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          strobes_o.alu_oe     = 1'b1;
          strobes_o.a_load     = 1'b1;
          strobes_o.flags_load = 1'b1;
          strobes_o.alu_sub    = (opcode_i == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// SAP-16 fetch/execute control sequencer: T-state register, next-state logic and
// reset-gated strobe outputs decoded by ctrl_decode.
module ctrl_seq
  import sap_isa_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   ir_opcode,
  input  logic               flag_c,
  input  logic               flag_z,
  output logic               pc_oe,
  output logic               ram_oe,
  output logic               ir_oe,
  output logic               a_oe,
  output logic               alu_oe,
  output logic               pc_inc,
  output logic               pc_write,
  output logic               mar_load,
  output logic               ir_load,
  output logic               a_load,
  output logic               b_load,
  output logic               flags_load,
  output logic               out_load,
  output logic               ram_we,
  output logic               alu_sub,
  output logic               halted,
  output logic [STATE_W-1:0] tstate
);

  tstate_e  state_q, state_d;
  strobes_t dec_strobes;
  logic     dec_end, dec_hlt;

  ctrl_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (ir_opcode),
    .flag_c_i  (flag_c),
    .flag_z_i  (flag_z),
    .strobes_o (dec_strobes),
    .end_o     (dec_end),
    .hlt_o     (dec_hlt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= T0;
    else     state_q <= state_d;
  end

  // Strobes are forced low during reset so a mid-instruction reset never leaks a partial step.
  always_comb begin
    state_d = state_q;
    {pc_oe, ram_oe, ir_oe, a_oe, alu_oe, pc_inc, pc_write, mar_load, ir_load,
     a_load, b_load, flags_load, out_load, ram_we, alu_sub} = '0;
    halted  = 1'b0;
    tstate  = STATE_W'(T0);
    case (state_q)
      T0:      state_d = T1;
      T1:      state_d = T2;
      T2:      state_d = dec_hlt ? HALT : (dec_end ? T0 : T3);
      T3:      state_d = dec_end ? T0 : T4;
      T4:      state_d = T0;
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase
    if (!rst) begin
      {pc_oe, ram_oe, ir_oe, a_oe, alu_oe, pc_inc, pc_write, mar_load, ir_load,
       a_load, b_load, flags_load, out_load, ram_we, alu_sub} = dec_strobes;
      halted = (state_q == HALT);
      tstate = STATE_W'(state_q);
    end
  end

  a_bus_onehot: assert property (@(posedge clk) $onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}));
  a_pc_excl:    assert property (@(posedge clk) !(pc_inc && pc_write));
  a_ram_excl:   assert property (@(posedge clk) !(ram_oe && ram_we));

endmodule
